// File: rtl/ikaopll_dac_acc_seq_if.sv
// Bus bundle for the accumulation-DAC sequencer: phi1 tick inputs, DAC word,
// volumes, sample handshake and status.
interface ikaopll_dac_acc_seq_if;
  logic       i_phi1_NCEN_n;
  logic       i_CYCLE_00;
  logic       i_DAC_EN_MO;
  logic       i_DAC_EN_RO;
  logic [8:0] i_SNDDATA;
  logic [4:0] i_MOVOL;
  logic [4:0] i_ROVOL;
  logic [15:0] o_SAMPLE;
  logic       o_SAMPLE_VALID;
  logic       i_SAMPLE_READY;
  logic [4:0] o_SLOT;
  logic [2:0] o_STATUS;
  logic       i_STATUS_CLR;

  modport master (
    output i_phi1_NCEN_n, i_CYCLE_00, i_DAC_EN_MO, i_DAC_EN_RO, i_SNDDATA,
           i_MOVOL, i_ROVOL, i_SAMPLE_READY, i_STATUS_CLR,
    input  o_SAMPLE, o_SAMPLE_VALID, o_SLOT, o_STATUS
  );

  modport slave (
    input  i_phi1_NCEN_n, i_CYCLE_00, i_DAC_EN_MO, i_DAC_EN_RO, i_SNDDATA,
           i_MOVOL, i_ROVOL, i_SAMPLE_READY, i_STATUS_CLR,
    output o_SAMPLE, o_SAMPLE_VALID, o_SLOT, o_STATUS
  );
endinterface

// File: rtl/ikaopll_dac_acc_seq.sv
// Accumulation-DAC sequencer: tracks the 18-slot phi1 cycle, accumulates
// volume-scaled MO/RO contributions and emits one saturated sample per frame.
module ikaopll_dac_acc_seq #(
  parameter int SLOTS = 18,
  parameter int ACC_W = 20,
  parameter int SHIFT = 2
) (
  input logic                   i_EMUCLK,
  input logic                   i_RST,
  ikaopll_dac_acc_seq_if.slave  bus
);

  localparam logic [0:0] ST_SYNC = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [4:0] LAST_SLOT = 5'(SLOTS - 1);
  localparam int SW = ACC_W + SHIFT;
  localparam logic signed [SW-1:0] P_MAX = SW'(32767);
  localparam logic signed [SW-1:0] P_MIN = SW'(-32768);

  logic [0:0]              r_state;
  logic [4:0]              r_slot;
  logic signed [ACC_W-1:0] r_acc;
  logic [15:0]             r_sample;
  logic                    r_valid;
  logic [2:0]              r_status;

  logic signed [8:0]       w_v;
  logic signed [4:0]       w_vol;
  logic                    w_en;
  logic signed [13:0]      w_prod;
  logic signed [ACC_W-1:0] w_c;
  logic [4:0]              w_cur;
  logic signed [SW-1:0]    w_shifted;
  logic [15:0]             w_sat;
  logic                    w_clamp;
  logic                    w_tick;
  logic                    w_run;
  logic                    w_close;
  logic                    w_emit;
  logic [2:0]              w_evt;

  // Sign-magnitude to two's complement: negative words map to -(mag+1).
  assign w_v = bus.i_SNDDATA[8] ? {1'b1, ~bus.i_SNDDATA[7:0]}
                                : {1'b0, bus.i_SNDDATA[7:0]};

  always_comb begin
    w_vol = bus.i_DAC_EN_RO ? bus.i_ROVOL : bus.i_MOVOL;
    w_en  = bus.i_DAC_EN_RO | bus.i_DAC_EN_MO;
  end

  assign w_prod = $signed({{5{w_v[8]}}, w_v}) * $signed({{9{w_vol[4]}}, w_vol});
  assign w_c    = w_en ? {{(ACC_W-14){w_prod[13]}}, w_prod} : '0;

  assign w_tick = ~bus.i_phi1_NCEN_n;
  assign w_run  = (r_state == ST_RUN);
  assign w_cur  = (bus.i_CYCLE_00 || r_slot == LAST_SLOT) ? 5'd0 : r_slot + 5'd1;

  assign w_shifted = $signed({r_acc, {SHIFT{1'b0}}});

  always_comb begin
    w_clamp = 1'b0;
    w_sat   = w_shifted[15:0];
    if (w_shifted > P_MAX) begin
      w_sat   = 16'h7FFF;
      w_clamp = 1'b1;
    end else if (w_shifted < P_MIN) begin
      w_sat   = 16'h8000;
      w_clamp = 1'b1;
    end
  end

  // A slot-0 boundary only closes a frame when slot 17 meets the cycle-0 marker.
  assign w_close = w_tick & w_run & (w_cur == 5'd0);
  assign w_emit  = w_close & (r_slot == LAST_SLOT) & bus.i_CYCLE_00;
  assign w_evt   = {w_close & ~w_emit,
                    w_emit & r_valid & ~bus.i_SAMPLE_READY,
                    w_emit & w_clamp};

  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      r_state  <= ST_SYNC;
      r_slot   <= '0;
      r_acc    <= '0;
      r_sample <= '0;
      r_valid  <= 1'b0;
      r_status <= '0;
    end else begin
      if (w_tick) begin
        if (!w_run) begin
          if (bus.i_CYCLE_00) begin
            r_state <= ST_RUN;
            r_slot  <= '0;
            r_acc   <= w_c;
          end
        end else begin
          r_slot <= w_cur;
          r_acc  <= (w_cur != 5'd0) ? r_acc + w_c : w_c;
        end
      end
      if (w_emit) begin
        r_sample <= w_sat;
        r_valid  <= 1'b1;
      end else if (r_valid && bus.i_SAMPLE_READY) begin
        r_valid <= 1'b0;
      end
      r_status <= w_evt | (bus.i_STATUS_CLR ? 3'b000 : r_status);
    end
  end

  assign bus.o_SAMPLE       = r_sample;
  assign bus.o_SAMPLE_VALID = r_valid;
  assign bus.o_SLOT         = r_slot;
  assign bus.o_STATUS       = r_status;

endmodule

// File: tb/tb_ikaopll_dac_acc_seq.sv
// Directed bench for ikaopll_dac_acc_seq: integer frame model compared every
// cycle, plus literal expectations for the documented scenarios.
module tb_ikaopll_dac_acc_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ikaopll_dac_acc_seq_if bus();

  ikaopll_dac_acc_seq #(.SLOTS(18), .ACC_W(20), .SHIFT(2)) dut (
    .i_EMUCLK (clk),
    .i_RST    (rst),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b1;

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Frame model in plain integers
  bit       m_sync = 0;
  int       m_slot = 0;
  int       m_sum = 0;
  int       m_sample = 0;
  int       m_last_sum = 0;
  bit       m_valid = 0;
  bit [2:0] m_status = '0;

  function automatic int operand(input logic [8:0] d);
    return d[8] ? -(int'(d[7:0]) + 1) : int'(d[7:0]);
  endfunction

  always @(posedge clk) begin : model
    int c, nxt, val;
    bit emit, clip, drop, res, old_valid;
    emit = 0; clip = 0; drop = 0; res = 0; val = 0;
    if (rst) begin
      m_sync = 0; m_slot = 0; m_sum = 0; m_sample = 0; m_valid = 0; m_status = '0;
    end else begin
      if (bus.i_DAC_EN_RO)      c = operand(bus.i_SNDDATA) * int'($signed(bus.i_ROVOL));
      else if (bus.i_DAC_EN_MO) c = operand(bus.i_SNDDATA) * int'($signed(bus.i_MOVOL));
      else                      c = 0;
      if (!bus.i_phi1_NCEN_n) begin
        if (!m_sync) begin
          if (bus.i_CYCLE_00) begin m_sync = 1; m_slot = 0; m_sum = c; end
        end else begin
          if (bus.i_CYCLE_00 || m_slot == 17) nxt = 0; else nxt = m_slot + 1;
          if (nxt != 0) m_sum = m_sum + c;
          else begin
            if (m_slot == 17 && bus.i_CYCLE_00) begin
              emit = 1;
              m_last_sum = m_sum;
              val = m_sum * 4;
              if (val > 32767) begin val = 32767; clip = 1; end
              if (val < -32768) begin val = -32768; clip = 1; end
            end else res = 1;
            m_sum = c;
          end
          m_slot = nxt;
        end
      end
      old_valid = m_valid;
      if (old_valid && bus.i_SAMPLE_READY) m_valid = 0;
      if (emit) begin
        if (old_valid && !bus.i_SAMPLE_READY) drop = 1;
        m_valid = 1;
        m_sample = val;
      end
      if (bus.i_STATUS_CLR) m_status = '0;
      m_status = m_status | {res, drop, clip};
    end
  end

  always begin
    @(posedge clk);
    #2;
    if (cmp_en) begin
      chk("sample", $signed(bus.o_SAMPLE), m_sample);
      chk("valid",  bus.o_SAMPLE_VALID, m_valid);
      chk("slot",   bus.o_SLOT, m_slot);
      chk("status", bus.o_STATUS, m_status);
    end
  end

  logic       s_mo [18];
  logic       s_ro [18];
  logic [8:0] s_dat[18];

  task automatic clear_slots();
    for (int s = 0; s < 18; s++) begin s_mo[s] = 0; s_ro[s] = 0; s_dat[s] = '0; end
  endtask

  task automatic tick(input bit c0, input bit mo, input bit ro, input logic [8:0] d);
    @(negedge clk);
    bus.i_phi1_NCEN_n = 1'b0; bus.i_CYCLE_00 = c0;
    bus.i_DAC_EN_MO = mo; bus.i_DAC_EN_RO = ro; bus.i_SNDDATA = d;
    @(negedge clk);
    bus.i_phi1_NCEN_n = 1'b1; bus.i_CYCLE_00 = 1'b0;
    bus.i_DAC_EN_MO = 1'b0; bus.i_DAC_EN_RO = 1'b0; bus.i_SNDDATA = '0;
  endtask

  // Slots 1..17 of the current frame, then the closing tick carrying next slot 0
  task automatic play_frame();
    for (int s = 1; s < 18; s++) tick(1'b0, s_mo[s], s_ro[s], s_dat[s]);
    tick(1'b1, s_mo[0], s_ro[0], s_dat[0]);
  endtask

  task automatic status_clear();
    @(negedge clk); bus.i_STATUS_CLR = 1'b1;
    @(negedge clk); bus.i_STATUS_CLR = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.i_phi1_NCEN_n = 1'b1; bus.i_CYCLE_00 = 1'b0;
    bus.i_DAC_EN_MO = 1'b0; bus.i_DAC_EN_RO = 1'b0; bus.i_SNDDATA = '0;
    bus.i_MOVOL = 5'd0; bus.i_ROVOL = 5'd0;
    bus.i_SAMPLE_READY = 1'b0; bus.i_STATUS_CLR = 1'b0;
    clear_slots();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Emit one held sample, start a partial frame, then reset with ticks running
    bus.i_MOVOL = 5'd1;
    tick(1'b1, 1'b0, 1'b0, 9'h000);
    s_mo[3] = 1; s_dat[3] = 9'h010;
    play_frame();
    chk("pre_rst_sample", $signed(bus.o_SAMPLE), 64);
    chk("pre_rst_valid", bus.o_SAMPLE_VALID, 1);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b0, 9'h020);
    @(negedge clk);
    rst = 1'b1; bus.i_phi1_NCEN_n = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0; bus.i_phi1_NCEN_n = 1'b1;
    chk("rst_sample", $signed(bus.o_SAMPLE), 0);
    chk("rst_valid", bus.o_SAMPLE_VALID, 0);
    chk("rst_status", bus.o_STATUS, 0);
    chk("rst_slot", bus.o_SLOT, 0);
    bus.i_SAMPLE_READY = 1'b1;
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b0, 9'h030);
    chk("sync_idle_slot", bus.o_SLOT, 0);
    chk("sync_idle_valid", bus.o_SAMPLE_VALID, 0);

    // Single MO slot
    clear_slots();
    bus.i_MOVOL = 5'd4;
    tick(1'b1, 1'b0, 1'b0, 9'h000);
    s_mo[5] = 1; s_dat[5] = 9'h064;
    play_frame();
    chk("mo_sample", $signed(bus.o_SAMPLE), 1600);
    chk("mo_valid", bus.o_SAMPLE_VALID, 1);
    chk("mo_status", bus.o_STATUS, 0);

    // RO priority with negative operand and volume
    clear_slots();
    bus.i_MOVOL = 5'd15; bus.i_ROVOL = 5'b10000;
    s_mo[3] = 1; s_ro[3] = 1; s_dat[3] = 9'h100;
    play_frame();
    chk("prio_sample", $signed(bus.o_SAMPLE), 64);

    // Saturation, positive then negative
    clear_slots();
    bus.i_MOVOL = 5'd15;
    for (int s = 0; s < 18; s++) begin s_mo[s] = 1; s_dat[s] = 9'h0FF; end
    play_frame();
    chk("sat17_sample", $signed(bus.o_SAMPLE), 32767);
    s_dat[0] = 9'h1FF;
    play_frame();
    chk("satp_sample", $signed(bus.o_SAMPLE), 32767);
    chk("satp_model_acc", m_last_sum, 68850);
    chk("satp_clip", bus.o_STATUS[0], 1);
    for (int s = 0; s < 18; s++) s_dat[s] = 9'h1FF;
    s_mo[0] = 0;
    play_frame();
    chk("satn_sample", $signed(bus.o_SAMPLE), -32768);
    chk("satn_model_acc", m_last_sum, -69120);
    status_clear();
    chk("clr_status", bus.o_STATUS, 0);

    // Backpressure across two frames
    clear_slots();
    bus.i_MOVOL = 5'd1;
    bus.i_SAMPLE_READY = 1'b0;
    s_mo[1] = 1; s_dat[1] = 9'd10;
    play_frame();
    chk("bp1_sample", $signed(bus.o_SAMPLE), 40);
    s_dat[1] = 9'd20;
    play_frame();
    chk("bp2_sample", $signed(bus.o_SAMPLE), 80);
    chk("bp2_valid", bus.o_SAMPLE_VALID, 1);
    chk("bp2_status", bus.o_STATUS, 3'b010);
    bus.i_SAMPLE_READY = 1'b1;
    @(negedge clk);
    chk("bp_accept_valid", bus.o_SAMPLE_VALID, 0);

    // Resync at slot 9, then a normal frame
    status_clear();
    for (int s = 1; s <= 9; s++) tick(1'b0, 1'b0, 1'b0, 9'h000);
    tick(1'b1, 1'b0, 1'b0, 9'h000);
    chk("resync_status", bus.o_STATUS, 3'b100);
    chk("resync_slot", bus.o_SLOT, 0);
    chk("resync_valid", bus.o_SAMPLE_VALID, 0);
    clear_slots();
    s_mo[2] = 1; s_dat[2] = 9'd5;
    play_frame();
    chk("after_resync_sample", $signed(bus.o_SAMPLE), 20);
    chk("after_resync_valid", bus.o_SAMPLE_VALID, 1);

    // Slot 17 wrapping without the cycle-0 marker
    status_clear();
    for (int i = 0; i < 17; i++) tick(1'b0, 1'b0, 1'b0, 9'h000);
    chk("wrap_pre_slot", bus.o_SLOT, 17);
    tick(1'b0, 1'b0, 1'b0, 9'h000);
    chk("wrap_slot", bus.o_SLOT, 0);
    chk("wrap_status", bus.o_STATUS, 3'b100);

    repeat (4) @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
